fifo_flex: RTL

- Synchronous single-clock FIFO, the successor to the basic element buffer.
- Supports any depth N (not only powers of two) and exposes occupancy and programmable almost-full/almost-empty thresholds.
- Accepts a write when full if a read happens in the same cycle, and has a synchronous flush.
- Sits between producer/consumer datapath stages that need backpressure warning ahead of full/empty.

---
 rtl/fifo_flex.sv | 82 ++++++++
 1 files changed

// File: rtl/fifo_flex.sv
// Single-clock FIFO of any depth N with occupancy count, almost-full/almost-empty thresholds and flush.
// Define FIFO_FLEX_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_flex #(
    parameter int N         = 5,
    parameter int M         = 16,
    parameter int AF_THRESH = N - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [M-1:0]           din,
    input  logic                   write,
    output logic                   full,
    output logic                   almost_full,
    output logic [M-1:0]           dout,
    input  logic                   read,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [$clog2(N+1)-1:0] count
`ifdef FIFO_FLEX_ERR_FLAGS_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int W  = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    logic [M-1:0] mem [N];
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         rd_ok;
    logic         wr_ok;
    logic         clear;

    // Wrap explicitly at N-1 so non-power-of-two depths never index past the array.
    function automatic logic [W-1:0] next_ptr(input logic [W-1:0] p);
        return (p == W'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    assign clear        = rst | flush;
    assign empty        = (count == '0);
    assign full         = (count == CW'(N));
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));
    assign rd_ok        = read & ~empty;
    assign wr_ok        = write & (~full | read);
    assign dout         = mem[head];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) tail <= next_ptr(tail);
            if (rd_ok) head <= next_ptr(head);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // NOTE: storage is deliberately not reset; empty qualifies dout, and a reset would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (wr_ok && !clear) mem[tail] <= din;
    end

`ifdef FIFO_FLEX_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && full && !read) overflow  <= 1'b1;
            if (read && empty)          underflow <= 1'b1;
        end
    end
`endif

endmodule
